uart_tx_peripheral: RTL and testbench

Memory-mapped UART transmitter on the CPU peripheral bus. It is written through the peripheral write-enable/address/data path of the core's MEM stage and read back combinationally on the peripheral read-data bus. It buffers bytes in a small FIFO and serialises them as 8N1, LSB first, on `txd`. It raises a level interrupt on one of the core's external `int_i` lines when transmission drains.

---
 rtl/uart_pkg.sv | 35 +++
 rtl/uart_tx_fifo.sv | 72 +++++++
 rtl/uart_tx_peripheral.sv | 189 ++++++++++++++++++
 tb/tb_uart_tx_peripheral.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared constants and types for the UART transmitter peripheral
//
// Holds the register offsets (decoded from addr[3:2]), the bit positions
// inside STATUS and CTRL, the transmitter state encoding and the reset
// baud divisor.
package uart_pkg;

  // Word offsets selected by addr[3:2]
  localparam logic [1:0] REG_TXDATA  = 2'd0;
  localparam logic [1:0] REG_STATUS  = 2'd1;
  localparam logic [1:0] REG_CTRL    = 2'd2;
  localparam logic [1:0] REG_BAUDDIV = 2'd3;

  // STATUS bit positions
  localparam int STAT_BUSY      = 0;
  localparam int STAT_FULL      = 1;
  localparam int STAT_EMPTY     = 2;
  localparam int STAT_OVF       = 3;
  localparam int STAT_COUNT_LSB = 8;

  // CTRL bit positions
  localparam int CTRL_TX_EN  = 0;
  localparam int CTRL_IRQ_EN = 1;

  // Reset baud divisor: 100 MHz / 115200 baud, in clk cycles per bit
  localparam int DEFAULT_DIV = 868;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_t;

endpackage

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - synchronous TX byte FIFO with occupancy count
//
// Ports:
//   clk    in   clock, rising edge
//   rst    in   asynchronous active-low reset (FIFO empty)
//   push   in   write din at the tail
//   din    in   WIDTH data to push
//   pop    in   advance the head
//   dout   out  head entry, combinational
//   full   out  count == DEPTH
//   empty  out  count == 0
//   count  out  occupancy, 0..DEPTH
module uart_tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign dout  = mem[rd_ptr];

  // A push into a full FIFO is still taken when the head leaves in the
  // same cycle; the freed slot is the one being written.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_peripheral.sv
// rtl/uart_tx_peripheral.sv - memory-mapped 8N1 UART transmitter with TX FIFO and irq
//
// Ports:
//   clk    in   clock, rising edge
//   rst    in   asynchronous active-low reset
//   addr   in   byte address; only addr[3:2] is decoded
//   wdata  in   store data
//   we     in   store strobe, one cycle per store
//   rdata  out  load data, combinational from addr[3:2]
//   txd    out  serial line, idle high, LSB first
//   irq    out  registered level interrupt: irq_en & fifo empty & idle
module uart_tx_peripheral #(
  parameter int FIFO_DEPTH  = 8,
  parameter int DEFAULT_DIV = uart_pkg::DEFAULT_DIV
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        we,
  output logic [31:0] rdata,
  output logic        txd,
  output logic        irq
);

  import uart_pkg::*;

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  logic [1:0]    reg_off;
  logic          wr_txdata;
  logic          wr_status;
  logic          wr_ctrl;
  logic          wr_baud;

  logic          tx_en;
  logic          irq_en;
  logic          overflow;
  logic [15:0]   div;

  tx_state_t     state;
  tx_state_t     state_next;
  logic [15:0]   baud_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift;
  logic          bit_end;
  logic          busy;

  logic          fifo_pop;
  logic          fifo_full;
  logic          fifo_empty;
  logic [7:0]    fifo_dout;
  logic [CW-1:0] fifo_count;

  // Address bits outside the decoded window and upper store bits are ignored.
  logic          unused_bits;
  assign unused_bits = ^{addr[31:4], addr[1:0], wdata[31:16]};

  assign reg_off   = addr[3:2];
  assign wr_txdata = we && (reg_off == REG_TXDATA);
  assign wr_status = we && (reg_off == REG_STATUS);
  assign wr_ctrl   = we && (reg_off == REG_CTRL);
  assign wr_baud   = we && (reg_off == REG_BAUDDIV);

  assign busy    = (state != ST_IDLE);
  assign bit_end = (baud_cnt == 16'd0);

  // A frame is only started from IDLE, so clearing tx_en lets the current
  // frame finish but stops further pops.
  assign fifo_pop = (state == ST_IDLE) && tx_en && !fifo_empty;

  uart_tx_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (wr_txdata),
    .din   (wdata[7:0]),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Register file and interrupt flop
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_en    <= 1'b1;
      irq_en   <= 1'b0;
      div      <= 16'(DEFAULT_DIV);
      overflow <= 1'b0;
      irq      <= 1'b0;
    end else begin
      if (wr_ctrl) begin
        tx_en  <= wdata[CTRL_TX_EN];
        irq_en <= wdata[CTRL_IRQ_EN];
      end
      // A zero divisor would never end a bit; the fastest legal rate is 1.
      if (wr_baud) begin
        div <= (wdata[15:0] == 16'd0) ? 16'd1 : wdata[15:0];
      end
      if (wr_txdata && fifo_full && !fifo_pop) begin
        overflow <= 1'b1;
      end else if (wr_status && wdata[STAT_OVF]) begin
        overflow <= 1'b0;
      end
      irq <= irq_en && fifo_empty && !busy;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // FSM next state
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (fifo_pop) state_next = ST_START;
      ST_START: if (bit_end) state_next = ST_DATA;
      ST_DATA:  if (bit_end && (bit_cnt == 3'd7)) state_next = ST_STOP;
      ST_STOP:  if (bit_end) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Baud counter, bit counter and shift register. The divisor is sampled
  // only when a bit is entered, so a BAUDDIV write lands on the next bit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
    end else if (state == ST_IDLE) begin
      if (fifo_pop) begin
        shift    <= fifo_dout;
        baud_cnt <= div - 16'd1;
        bit_cnt  <= '0;
      end
    end else if (bit_end) begin
      baud_cnt <= div - 16'd1;
      if (state == ST_DATA) begin
        shift   <= {1'b0, shift[7:1]};
        bit_cnt <= bit_cnt + 3'd1;
      end
    end else begin
      baud_cnt <= baud_cnt - 16'd1;
    end
  end

  // Line driven straight from state so reset returns it high immediately.
  always_comb begin
    txd = 1'b1;
    case (state)
      ST_START: txd = 1'b0;
      ST_DATA:  txd = shift[0];
      default:  txd = 1'b1;
    endcase
  end

  // Read mux
  always_comb begin
    rdata = '0;
    case (reg_off)
      REG_STATUS: begin
        rdata[STAT_BUSY]                = busy;
        rdata[STAT_FULL]                = fifo_full;
        rdata[STAT_EMPTY]               = fifo_empty;
        rdata[STAT_OVF]                 = overflow;
        rdata[STAT_COUNT_LSB +: CW]     = fifo_count;
      end
      REG_CTRL: begin
        rdata[CTRL_TX_EN]  = tx_en;
        rdata[CTRL_IRQ_EN] = irq_en;
      end
      REG_BAUDDIV: rdata[15:0] = div;
      default:     rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_peripheral.sv
// tb/tb_uart_tx_peripheral.sv - self-checking bench for uart_tx_peripheral
module tb_uart_tx_peripheral;

  import uart_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        we = 1'b0;
  logic [31:0] rdata;
  logic        txd;
  logic        irq;

  int checks = 0;
  int failures = 0;

  // Expected txd level, one entry per clock cycle
  bit exp_q[$];

  typedef struct {
    bit          do_wr;
    logic [1:0]  off;
    logic [31:0] wd;
    logic [31:0] exp;
    string       name;
  } vec_t;

  uart_tx_peripheral dut (
    .clk   (clk),
    .rst   (rst),
    .addr  (addr),
    .wdata (wdata),
    .we    (we),
    .rdata (rdata),
    .txd   (txd),
    .irq   (irq)
  );

  always #5 clk = ~clk;

  initial begin
    #600000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", name, got, exp);
    end
  endtask

  // Called at a negedge; the store lands on the next posedge and the task
  // returns at the following negedge.
  task automatic write_reg(logic [1:0] off, logic [31:0] d);
    addr  = {28'd0, off, 2'b00};
    wdata = d;
    we    = 1'b1;
    @(negedge clk);
    we    = 1'b0;
  endtask

  task automatic read_reg(logic [1:0] off, output logic [31:0] d);
    addr = {28'd0, off, 2'b00};
    #1;
    d = rdata;
  endtask

  task automatic add_level(bit v, int n);
    repeat (n) exp_q.push_back(v);
  endtask

  // 8N1 frame: start 0, eight data bits LSB first, stop 1; div cycles each
  task automatic add_frame(logic [7:0] b, int div);
    add_level(1'b0, div);
    for (int i = 0; i < 8; i++) add_level(b[i], div);
    add_level(1'b1, div);
  endtask

  // Back-to-back frames separated by exactly one idle-high cycle
  task automatic add_frames(logic [7:0] bytes[$], int div);
    for (int i = 0; i < bytes.size(); i++) begin
      add_frame(bytes[i], div);
      if (i != bytes.size() - 1) add_level(1'b1, 1);
    end
  endtask

  task automatic check_wave(string name);
    int   bad = -1;
    logic got = 1'b0;
    logic want = 1'b0;
    for (int i = 0; i < exp_q.size(); i++) begin
      if ((txd !== exp_q[i]) && (bad < 0)) begin
        bad  = i;
        got  = txd;
        want = exp_q[i];
      end
      @(negedge clk);
    end
    checks++;
    if (bad >= 0) begin
      failures++;
      $display("FAIL %s cycle=%0d txd=%0b exp=%0b", name, bad, got, want);
    end
    exp_q.delete();
  endtask

  initial begin
    vec_t        vecs[$];
    logic [31:0] rd;
    logic [7:0]  bq[$];
    int          div;
    int          n;
    int          bad;
    logic        exp_irq;
    logic        exp_busy;

    vecs.push_back('{1'b0, REG_STATUS,  32'h0,        32'h4,   "rst_status"});
    vecs.push_back('{1'b0, REG_CTRL,    32'h0,        32'h1,   "rst_ctrl"});
    vecs.push_back('{1'b0, REG_BAUDDIV, 32'h0,        32'd868, "rst_bauddiv"});
    vecs.push_back('{1'b0, REG_TXDATA,  32'h0,        32'h0,   "txdata_reads_0"});
    vecs.push_back('{1'b1, REG_CTRL,    32'h2,        32'h2,   "ctrl_irq_only"});
    vecs.push_back('{1'b1, REG_CTRL,    32'hFFFF_FFF1, 32'h1,  "ctrl_tx_only"});
    vecs.push_back('{1'b1, REG_BAUDDIV, 32'h0,        32'h1,   "baud_zero_is_1"});
    vecs.push_back('{1'b1, REG_BAUDDIV, 32'hABCD_1234, 32'h1234, "baud_16bit"});
    vecs.push_back('{1'b1, REG_STATUS,  32'hFFFF_FFFF, 32'h4,  "status_wr_noeffect"});
    vecs.push_back('{1'b1, REG_BAUDDIV, 32'h0000_FFFF, 32'hFFFF, "baud_max"});

    rst = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    foreach (vecs[i]) begin
      if (vecs[i].do_wr) write_reg(vecs[i].off, vecs[i].wd);
      read_reg(vecs[i].off, rd);
      chk(vecs[i].name, rd, vecs[i].exp);
    end
    chk("irq_off_when_disabled", irq, 1'b0);

    // Divisor 0 -> one cycle per bit
    write_reg(REG_BAUDDIV, 32'h0);
    write_reg(REG_TXDATA, 32'h3C);
    add_level(1'b1, 1);
    add_frame(8'h3C, 1);
    add_level(1'b1, 3);
    check_wave("wave_div1");

    // Single byte 0xA5 at DIV=4
    write_reg(REG_BAUDDIV, 32'd4);
    write_reg(REG_TXDATA, 32'hA5);
    add_level(1'b1, 1);
    add_frame(8'hA5, 4);
    add_level(1'b1, 2);
    check_wave("wave_a5_div4");
    read_reg(REG_STATUS, rd);
    chk("status_after_a5", rd, 32'h4);

    // FIFO full / overflow with tx disabled, then push+pop in the same cycle
    write_reg(REG_BAUDDIV, 32'd2);
    write_reg(REG_CTRL, 32'h0);
    bq.delete();
    for (int i = 0; i < 9; i++) begin
      write_reg(REG_TXDATA, 32'h10 + i);
      if (i < 8) bq.push_back(8'(8'h10 + i));
    end
    read_reg(REG_STATUS, rd);
    chk("status_full_ovf", rd, 32'h80A);
    write_reg(REG_STATUS, 32'h8);
    read_reg(REG_STATUS, rd);
    chk("status_ovf_cleared", rd, 32'h802);
    write_reg(REG_CTRL, 32'h1);
    write_reg(REG_TXDATA, 32'h5A);
    read_reg(REG_STATUS, rd);
    chk("status_push_pop_full", rd, 32'h803);
    bq.push_back(8'h5A);
    add_frames(bq, 2);
    add_level(1'b1, 2);
    check_wave("wave_fifo_drain");
    read_reg(REG_STATUS, rd);
    chk("status_drained", rd, 32'h4);

    // Three back-to-back frames at DIV=2
    write_reg(REG_CTRL, 32'h0);
    bq = '{8'h01, 8'h80, 8'hFF};
    foreach (bq[i]) write_reg(REG_TXDATA, {24'd0, bq[i]});
    write_reg(REG_CTRL, 32'h1);
    add_level(1'b1, 1);
    add_frames(bq, 2);
    add_level(1'b1, 2);
    check_wave("wave_b2b_3");

    // Interrupt: high while idle+empty, low through the frame
    write_reg(REG_BAUDDIV, 32'd3);
    write_reg(REG_CTRL, 32'h3);
    @(negedge clk);
    chk("irq_idle_empty", irq, 1'b1);
    write_reg(REG_TXDATA, 32'h81);
    bad = -1;
    for (int k = 0; k < 36; k++) begin
      read_reg(REG_STATUS, rd);
      exp_irq  = (k == 0) || (k >= 32);
      exp_busy = (k >= 1) && (k <= 30);
      if (((irq !== exp_irq) || (rd[0] !== exp_busy)) && (bad < 0)) begin
        bad = k;
        checks++;
        failures++;
        $display("FAIL irq_busy_seq k=%0d irq=%0b busy=%0b exp_irq=%0b exp_busy=%0b",
                 k, irq, rd[0], exp_irq, exp_busy);
      end
      @(negedge clk);
    end
    if (bad < 0) checks++;
    write_reg(REG_CTRL, 32'h1);
    chk("irq_hold_one_cycle", irq, 1'b1);
    @(negedge clk);
    chk("irq_disabled", irq, 1'b0);

    // BAUDDIV 8 -> 3 during data bit 1
    write_reg(REG_BAUDDIV, 32'd8);
    write_reg(REG_TXDATA, 32'hC6);
    add_level(1'b1, 1);
    add_level(1'b0, 8);
    add_level(1'b0, 8);
    add_level(1'b1, 8);
    for (int i = 2; i < 8; i++) add_level(((8'hC6 >> i) & 8'h1) != 0, 3);
    add_level(1'b1, 3);
    add_level(1'b1, 2);
    fork
      check_wave("wave_div_change");
      begin
        repeat (18) @(negedge clk);
        write_reg(REG_BAUDDIV, 32'd3);
      end
    join
    read_reg(REG_BAUDDIV, rd);
    chk("baud_after_change", rd, 32'd3);

    // Randomized bursts against the frame model
    for (int it = 0; it < 6; it++) begin
      div = $urandom_range(1, 6);
      n   = $urandom_range(1, 8);
      write_reg(REG_CTRL, 32'h0);
      write_reg(REG_BAUDDIV, div);
      bq.delete();
      for (int i = 0; i < n; i++) begin
        bq.push_back(8'($urandom));
        write_reg(REG_TXDATA, {24'd0, bq[i]});
      end
      read_reg(REG_STATUS, rd);
      chk($sformatf("rand%0d_status", it), rd, (n << 8) | ((n == 8) ? 32'h2 : 32'h0));
      write_reg(REG_CTRL, 32'h1);
      add_level(1'b1, 1);
      add_frames(bq, div);
      add_level(1'b1, 2);
      check_wave($sformatf("rand%0d_wave_div%0d_n%0d", it, div, n));
    end

    // Reset mid-frame
    write_reg(REG_BAUDDIV, 32'd5);
    write_reg(REG_CTRL, 32'h3);
    write_reg(REG_TXDATA, 32'h00);
    write_reg(REG_TXDATA, 32'h77);
    @(negedge clk);
    chk("pre_reset_txd_low", txd, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    chk("reset_txd_high", txd, 1'b1);
    chk("reset_irq_low", irq, 1'b0);
    read_reg(REG_STATUS, rd);
    chk("reset_status", rd, 32'h4);
    read_reg(REG_CTRL, rd);
    chk("reset_ctrl", rd, 32'h1);
    read_reg(REG_BAUDDIV, rd);
    chk("reset_bauddiv", rd, 32'd868);
    @(negedge clk);
    rst = 1'b1;
    add_level(1'b1, 6);
    check_wave("post_reset_idle");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
